// File: rtl/countdown_timer_if.sv
// Command/status bundle for countdown_timer: control inputs from the master,
// registered count/status back from the timer.
interface countdown_timer_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             stop;
  logic             en;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic [1:0]       state;

  modport master (
    output load, load_val, start, stop, en, auto_reload,
    input  count, busy, done, state
  );

  modport slave (
    input  load, load_val, start, stop, en, auto_reload,
    output count, busy, done, state
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter: one-shot or auto-reload countdown on en ticks, with a
// single-cycle registered done pulse on expiry.
module countdown_timer #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  countdown_timer_if.slave   tmr
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HOLD    = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  // Next-state decode; load overrides everything, then stop beats start.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    if (tmr.load) begin
      count_d  = tmr.load_val;
      reload_d = tmr.load_val;
      state_d  = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tmr.start && !tmr.stop && (count_q != '0)) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (tmr.stop) begin
            state_d = ST_HOLD;
          end else if (tmr.en) begin
            if (count_q > WIDTH'(1'b1)) begin
              count_d = count_q - WIDTH'(1'b1);
            end else if (count_q == WIDTH'(1'b1)) begin
              done_d = 1'b1;
              if (tmr.auto_reload) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = ST_EXPIRED;
              end
            end else begin
              count_d = count_q;
            end
          end else begin
            count_d = count_q;
          end
        end
        ST_HOLD: begin
          if (tmr.start && !tmr.stop) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_HOLD;
          end
        end
        ST_EXPIRED: begin
          // Restart from the reload value; a zero reload cannot be restarted.
          if (tmr.start && !tmr.stop && (reload_q != '0)) begin
            count_d = reload_q;
            state_d = ST_RUN;
          end else begin
            state_d = ST_EXPIRED;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    busy_d = (state_d == ST_RUN) || (state_d == ST_HOLD);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign tmr.count = count_q;
  assign tmr.busy  = busy_q;
  assign tmr.done  = done_q;
  assign tmr.state = state_q;

endmodule
